valid2size_packer: RTL

- Inverse direction of the mode-level size-to-validity expansion.
- Consumes bus words that carry a thermometer byte-validity mask and recovers the byte count of each word.
- Packs the words into full datapath blocks and emits each block with its byte size and a last flag.
- Sits between the 32-bit external input bus and the Spook mode controller's block-size logic.

---
 rtl/valid2size_packer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/valid2size_packer.sv
// valid2size_packer: turns bus words carrying a thermometer byte-validity mask
// back into byte counts, and packs the words into full datapath blocks that
// are emitted with their byte size and a segment-last flag.
module valid2size_packer #(
  parameter int BUS_SIZE   = 32,
  parameter int BLOCK_SIZE = 128
) (
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic                                 clear,
  input  logic [BUS_SIZE-1:0]                  data_in,
  input  logic [BUS_SIZE/8-1:0]                validity_in,
  input  logic                                 last_in,
  input  logic                                 valid_in,
  output logic                                 ready_in,
  output logic [BLOCK_SIZE-1:0]                block_out,
  output logic [$clog2(BLOCK_SIZE/8+1)-1:0]    block_size,
  output logic                                 block_last,
  output logic                                 block_valid,
  input  logic                                 block_ready,
  output logic                                 err_mask
);

  localparam int BYTES_IN = BUS_SIZE / 8;
  localparam int WORDS    = BLOCK_SIZE / BUS_SIZE;
  localparam int SIZE_W   = $clog2(BLOCK_SIZE / 8 + 1);
  localparam int C_W      = $clog2(BYTES_IN + 1);
  localparam int WIDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);

  typedef enum logic {ST_FILL, ST_OUT} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [WIDX_W-1:0]      widx;
  logic [SIZE_W-1:0]      count;
  logic [BLOCK_SIZE-1:0]  buffer;
  logic                   last_q;
  logic                   err_q;

  logic [C_W-1:0]         c_cnt;
  logic                   mask_bad;
  logic                   seen_zero;
  logic [BUS_SIZE-1:0]    word_masked;
  logic                   accept;
  logic                   close_block;

  // Decode the mask: count leading ones, zero the invalid bytes, flag stray ones
  always_comb begin
    c_cnt       = '0;
    mask_bad    = 1'b0;
    seen_zero   = 1'b0;
    word_masked = '0;
    for (int i = 0; i < BYTES_IN; i++) begin
      if (validity_in[i]) begin
        if (seen_zero) begin
          mask_bad = 1'b1;
        end else begin
          c_cnt = c_cnt + C_W'(1);
          word_masked[i*8 +: 8] = data_in[i*8 +: 8];
        end
      end else begin
        seen_zero = 1'b1;
      end
    end
  end

  assign close_block = (widx == LAST_IDX) || last_in || (c_cnt != C_W'(BYTES_IN));

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_FILL;
    else       state <= state_next;
  end

  // Next-state and handshake outputs; clear overrides every handshake
  always_comb begin
    state_next  = state;
    ready_in    = 1'b0;
    block_valid = 1'b0;
    accept      = 1'b0;
    case (state)
      ST_FILL: begin
        ready_in = 1'b1;
        accept   = valid_in && !clear;
        if (accept && close_block) state_next = ST_OUT;
      end
      ST_OUT: begin
        block_valid = 1'b1;
        if (block_ready) state_next = ST_FILL;
      end
      default: state_next = ST_FILL;
    endcase
    if (clear) state_next = ST_FILL;
  end

  // Block buffer, byte count, word index and sticky mask-error flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      widx   <= '0;
      count  <= '0;
      buffer <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (clear) begin
      widx   <= '0;
      count  <= '0;
      buffer <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < WORDS; k++) begin
        if (widx == WIDX_W'(k)) buffer[k*BUS_SIZE +: BUS_SIZE] <= word_masked;
      end
      count  <= count + SIZE_W'(c_cnt);
      widx   <= widx + WIDX_W'(1);
      last_q <= last_in;
      if (mask_bad) err_q <= 1'b1;
    end else if (block_valid && block_ready) begin
      widx   <= '0;
      count  <= '0;
      buffer <= '0;
      last_q <= 1'b0;
    end
  end

  assign block_out  = buffer;
  assign block_size = count;
  assign block_last = last_q;
  assign err_mask   = err_q;

endmodule
